// File: rtl/alu_operand_driver.sv
// Serialises a host ALU request into X/Y/opcode valid-ready beats and returns the captured result; done 6 cycles after start at best.
// Beats hold until alu_ready accepts them; optional wait-state abort via ALU_DRV_TIMEOUT_EN.
module alu_operand_driver #(
    parameter int w       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    input  logic [1:0]   opcode,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [w-1:0] result,
    output logic         overflow,
    output logic         cout,
    output logic         divizor_zero,
    output logic         timeout,
    output logic [w-1:0] alu_in,
    output logic         alu_valid,
    output logic         alu_cin,
    input  logic [w-1:0] alu_o,
    input  logic         alu_ready,
    input  logic         alu_overflow,
    input  logic         alu_cout,
    input  logic         alu_divizor_zero
);

    typedef enum logic [2:0] {
        IDLE, SEND_X, SEND_Y, SEND_OP, WAIT_LOW, WAIT_HIGH, DONE
    } state_t;

    state_t         state_q;
    logic [w-1:0]   b_q;
    logic [1:0]     op_q;
    logic           busy_q, done_q, ovf_q, cout_q, dz_q, timeout_q;
    logic           alu_valid_q, alu_cin_q;
    logic [w-1:0]   result_q, alu_in_q;
    logic           to_hit;

`ifdef ALU_DRV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    assign to_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == SEND_OP && alu_ready) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_LOW || state_q == WAIT_HIGH) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            b_q         <= '0;
            op_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            cout_q      <= 1'b0;
            dz_q        <= 1'b0;
            timeout_q   <= 1'b0;
            alu_in_q    <= '0;
            alu_valid_q <= 1'b0;
            alu_cin_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        b_q         <= b;
                        op_q        <= opcode;
                        alu_in_q    <= a;
                        alu_cin_q   <= cin;
                        alu_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        timeout_q   <= 1'b0;
                        state_q     <= SEND_X;
                    end
                end
                SEND_X: begin
                    if (alu_ready) begin
                        alu_in_q <= b_q;
                        state_q  <= SEND_Y;
                    end
                end
                SEND_Y: begin
                    if (alu_ready) begin
                        alu_in_q <= {{(w-2){1'b0}}, op_q};
                        state_q  <= SEND_OP;
                    end
                end
                SEND_OP: begin
                    if (alu_ready) begin
                        alu_valid_q <= 1'b0;
                        alu_in_q    <= '0;
                        state_q     <= WAIT_LOW;
                    end
                end
                WAIT_LOW, WAIT_HIGH: begin
                    // A completing ALU wins over an abort landing on the same edge.
                    if (state_q == WAIT_HIGH && alu_ready) begin
                        result_q  <= alu_o;
                        ovf_q     <= alu_overflow;
                        cout_q    <= alu_cout;
                        dz_q      <= alu_divizor_zero;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        alu_cin_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (to_hit) begin
                        result_q  <= '0;
                        ovf_q     <= 1'b0;
                        cout_q    <= 1'b0;
                        dz_q      <= 1'b0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        alu_cin_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (state_q == WAIT_LOW && !alu_ready) begin
                        state_q <= WAIT_HIGH;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign overflow     = ovf_q;
    assign cout         = cout_q;
    assign divizor_zero = dz_q;
    assign timeout      = timeout_q;
    assign alu_in       = alu_in_q;
    assign alu_valid    = alu_valid_q;
    assign alu_cin      = alu_cin_q;

endmodule

// File: doc/alu_operand_driver.md
Name: alu_operand_driver

Overview:
- Initiator side of the serial ALU load interface: takes a parallel request (operand A, operand B, 2-bit opcode, carry-in) from a host.
- Serialises the request onto the ALU's single w-bit input bus as three valid/ready beats: X, then Y, then opcode.
- Waits for the ALU to finish, then returns the result and status flags to the host with a one-cycle done pulse.
- Sits between a host sequencer/testbench and the alu block; shares clk and rst with it.

Parameters:
- w, 8, data width of operands, ALU bus and result.
- TIMEOUT, 64, cycles allowed in the wait states before aborting (used only with the optional feature).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  host request strobe.
- a  input  w  operand X.
- b  input  w  operand Y.
- opcode  input  2  ALU operation: 00 add, 01 sub, 10 mul, 11 div.
- cin  input  1  carry-in for the transaction.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- result  output  w  captured ALU result.
- overflow  output  1  captured ALU overflow.
- cout  output  1  captured ALU carry-out.
- divizor_zero  output  1  captured ALU divide-by-zero flag.
- timeout  output  1  transaction aborted (optional feature only; tied 0 otherwise).
- alu_in  output  w  serial load bus to the ALU.
- alu_valid  output  1  beat valid.
- alu_cin  output  1  carry-in to the ALU.
- alu_o  input  w  ALU result.
- alu_ready  input  1  ALU ready/accept.
- alu_overflow, alu_cout, alu_divizor_zero  input  1 each  ALU status flags.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising clk edge. When rst=0, all outputs go to 0 and the state goes to IDLE: busy, done, result, overflow, cout, divizor_zero, timeout, alu_in, alu_valid, alu_cin. Reset mid-transaction aborts immediately; no done pulse is produced.
- States: IDLE, SEND_X, SEND_Y, SEND_OP, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE:
  - busy=0, alu_valid=0.
  - On start=1, latch a, b, opcode and cin into internal registers and go to SEND_X.
  - Host inputs are not sampled again until the next IDLE.
- SEND_X / SEND_Y / SEND_OP:
  - busy=1, alu_valid=1, alu_cin = latched cin.
  - alu_in carries latched a, latched b, and {(w-2)'b0, latched opcode} respectively.
  - A beat is accepted on a rising edge with alu_valid=1 and alu_ready=1; only then advance to the next state.
  - alu_in and alu_valid are held stable until the beat is accepted.
  - After the SEND_OP beat is accepted, go to WAIT_LOW.
- WAIT_LOW:
  - alu_valid=0; wait for alu_ready=0 (ALU computing).
  - alu_ready=0 sampled: go to WAIT_HIGH.
- WAIT_HIGH:
  - Wait for alu_ready=1.
  - On that edge, capture alu_o into result and the three flags into overflow/cout/divizor_zero; go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0; next state IDLE.
  - result and flags hold until the next capture or reset.
- Start handling:
  - start while busy=1 is ignored (no queueing).
  - start asserted in the DONE cycle is also ignored; it is honoured only in IDLE.
- Minimum latency, with alu_ready high for all beats and the ALU dropping ready for one cycle: start at cycle 0, X beat at cycle 1, Y at 2, OP at 3, ready low at 4, ready high at 5, done=1 at cycle 6.
- alu_cin: driven with the latched cin during SEND_X through WAIT_HIGH, 0 otherwise.
- The driver performs no arithmetic; flags are passed through unmodified.

Optional Feature:
- Macro ALU_DRV_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT+1) clears on entering WAIT_LOW and counts while in WAIT_LOW or WAIT_HIGH.
  - On reaching TIMEOUT: go to DONE with timeout=1 and result/flags forced to 0.
  - timeout holds until the next start is accepted or reset.
- Not defined: the counter is absent, the wait states wait indefinitely, and timeout is tied to 0.

Test Plan:
- Reset: rst=0 for 2 cycles mid-SEND_Y -> busy=0, alu_valid=0, done never pulses; next start(a=8'h05) drives alu_in=8'h05 first.
- Add: a=8'h0F, b=8'h01, opcode=00, cin=0; ALU model returns 8'h10 -> beats 0F, 01, 00 in order; done pulse at cycle 6; result=8'h10, cout=0.
- Back-pressure: alu_ready=0 for 3 cycles during SEND_Y -> alu_in stays 8'h01 with alu_valid=1 throughout; advances only on the accepted edge.
- Divide by zero: a=8'h09, b=8'h00, opcode=11; model sets divizor_zero=1 -> divizor_zero=1 captured with done.
- Ignored start: start pulsed with a=8'hAA at cycle 2 of a transaction -> the in-flight beats are unchanged; no second transaction.
- With ALU_DRV_TIMEOUT_EN and TIMEOUT=4: ALU holds ready low forever -> done and timeout=1 four cycles after entering WAIT_LOW, result=0.
